// File: rtl/axi_burst_write_master_if.sv
// Bundle of the DMA-side control, FIFO and AXI4 write-channel signals of axi_burst_write_master.
interface axi_burst_write_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 32
);
  localparam int BPB = DATA_W / 8;

  logic              i_start;
  logic [ADDR_W-1:0] i_dst_addr;
  logic [LEN_W-1:0]  i_total_len;
  logic              o_busy;
  logic              o_write_done;
  logic              o_error;

  logic              i_fifo_empty;
  logic              o_fifo_rd_en;
  logic [DATA_W-1:0] i_w_data;

  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;

  logic [DATA_W-1:0] m_axi_wdata;
  logic [BPB-1:0]    m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;

  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  modport master (
    input  i_start, i_dst_addr, i_total_len, i_fifo_empty, i_w_data,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output o_busy, o_write_done, o_error, o_fifo_rd_en,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );

  modport slave (
    output i_start, i_dst_addr, i_total_len, i_fifo_empty, i_w_data,
           m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  o_busy, o_write_done, o_error, o_fifo_rd_en,
           m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
           m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready
  );
endinterface

// File: rtl/axi_burst_write_master.sv
// AXI4 write master: drains a FWFT FIFO to memory as INCR bursts of at most MAX_BURST beats,
// never crossing a 4 KB page, one burst outstanding, sticky error on any non-OKAY response.
module axi_burst_write_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 32
) (
  input logic                      clk,
  input logic                      reset_n,
  axi_burst_write_master_if.master bus
);
  localparam int BPB = DATA_W / 8;
  localparam int SZ  = $clog2(BPB);

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  beats_left;
  logic [8:0]        burst;
  logic [8:0]        beat_cnt;
  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic              bready;
  logic              busy;
  logic              done;
  logic              error;

  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  base_left;
  logic [12:0]       page_beats;
  logic [12:0]       cap;
  logic [8:0]        next_burst;
  logic              wvalid;
  logic              w_hs;

  // Address/remaining-beats for the next burst: taken from the start request in IDLE,
  // otherwise advanced past the burst that has just been acknowledged.
  always_comb begin
    if (state == IDLE) begin
      base_addr = bus.i_dst_addr & ~ADDR_W'(BPB - 1);
      base_left = bus.i_total_len >> SZ;
    end else begin
      base_addr = addr + (ADDR_W'(burst) << SZ);
      base_left = beats_left - LEN_W'(burst);
    end
    page_beats = (13'd4096 - {1'b0, base_addr[11:0]}) >> SZ;
    cap        = (page_beats > 13'(MAX_BURST)) ? 13'(MAX_BURST) : page_beats;
    next_burst = (base_left < LEN_W'(cap)) ? 9'(base_left) : 9'(cap);
  end

  assign wvalid = (state == W) && !bus.i_fifo_empty;
  assign w_hs   = wvalid && bus.m_axi_wready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      beats_left <= '0;
      burst      <= '0;
      beat_cnt   <= '0;
      awvalid    <= 1'b0;
      awaddr     <= '0;
      awlen      <= '0;
      bready     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            addr       <= base_addr;
            beats_left <= base_left;
            error      <= 1'b0;
            busy       <= 1'b1;
            if (base_left == '0) begin
              state <= DONE;
            end else begin
              state   <= AW;
              awvalid <= 1'b1;
              awaddr  <= base_addr;
              awlen   <= 8'(next_burst - 9'd1);
              burst   <= next_burst;
            end
          end
        end
        AW: begin
          if (bus.m_axi_awready) begin
            awvalid  <= 1'b0;
            beat_cnt <= burst;
            state    <= W;
          end
        end
        W: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt - 9'd1;
            if (beat_cnt == 9'd1) begin
              bready <= 1'b1;
              state  <= B;
            end
          end
        end
        B: begin
          if (bus.m_axi_bvalid) begin
            bready     <= 1'b0;
            addr       <= base_addr;
            beats_left <= base_left;
            if (bus.m_axi_bresp != 2'b00) error <= 1'b1;
            if (base_left != '0) begin
              state   <= AW;
              awvalid <= 1'b1;
              awaddr  <= base_addr;
              awlen   <= 8'(next_burst - 9'd1);
              burst   <= next_burst;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_axi_awaddr  = awaddr;
  assign bus.m_axi_awlen   = awlen;
  assign bus.m_axi_awsize  = 3'(SZ);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_wdata   = bus.i_w_data;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = (state == W) && (beat_cnt == 9'd1);
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_bready  = bready;
  assign bus.o_fifo_rd_en  = w_hs;
  assign bus.o_busy        = busy;
  assign bus.o_write_done  = done;
  assign bus.o_error       = error;
endmodule

// File: tb/tb_axi_burst_write_master.sv
// Randomised bench for axi_burst_write_master: an AXI slave/FIFO responder plus a burst-splitting
// reference model computed directly from address/length arithmetic.
module tb_axi_burst_write_master;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  axi_burst_write_master_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(32)) bus ();

  axi_burst_write_master #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .LEN_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  // Owned by the main initial block
  int          aw_delay, w_delay, b_delay, err_burst;
  bit          w_rand, empty_rand;
  logic [31:0] xfer_base;
  int          xfer_beats;
  int          xfer_id;

  // Owned by the responder/monitor process
  logic [31:0] aw_addr_log[$];
  logic [7:0]  aw_len_log[$];
  logic [31:0] w_data_log[$];
  bit          w_last_log[$];
  int          done_cnt, aw_valid_cycles, viol;

  // Reference model output
  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  bit          exp_last[$];

  function automatic void build_model(input logic [31:0] a, input logic [31:0] len);
    longint unsigned cur, beats, room, b;
    exp_addr.delete(); exp_len.delete(); exp_last.delete();
    cur   = longint'(a) & 64'hFFFF_FFFC;
    beats = longint'(len) / 4;
    while (beats > 0) begin
      room = (4096 - (cur % 4096)) / 4;
      b = beats;
      if (b > MAXB) b = MAXB;
      if (b > room) b = room;
      exp_addr.push_back(32'(cur));
      exp_len.push_back(8'(b - 1));
      for (longint unsigned k = 0; k < b; k++) exp_last.push_back(k == b - 1);
      cur   = (cur + b * 4) % 64'h1_0000_0000;
      beats = beats - b;
    end
  endfunction

  initial begin : responder
    int          aw_wait, w_wait, b_wait, b_pending, b_index, seen_id, rd_ptr;
    int          aw_hs_cnt, wlast_cnt;
    bit          b_taken, w_taken, aw_stall, w_stall, fifo_hold;
    logic [31:0] stall_addr;
    logic [7:0]  stall_len;
    aw_wait = 0; w_wait = 0; b_wait = 0; b_pending = 0; b_index = 0; seen_id = 0; rd_ptr = 0;
    aw_hs_cnt = 0; wlast_cnt = 0; b_taken = 0; w_taken = 0; aw_stall = 0; w_stall = 0;
    fifo_hold = 0; stall_addr = '0; stall_len = '0;
    done_cnt = 0; aw_valid_cycles = 0; viol = 0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
    bus.i_fifo_empty = 1'b1; bus.i_w_data = '0;
    forever begin
      @(posedge clk);
      if (reset_n) begin
        if (aw_stall && (!bus.m_axi_awvalid || bus.m_axi_awaddr !== stall_addr ||
                         bus.m_axi_awlen !== stall_len)) viol++;
        if (w_stall && !bus.m_axi_wvalid) viol++;
        if (bus.m_axi_wvalid && bus.i_fifo_empty) viol++;
        if (bus.m_axi_wvalid && aw_hs_cnt == wlast_cnt) viol++;
        if (bus.o_fifo_rd_en !== (bus.m_axi_wvalid && bus.m_axi_wready)) viol++;
        if (bus.m_axi_wvalid && bus.m_axi_wdata !== bus.i_w_data) viol++;
        aw_stall   = bus.m_axi_awvalid && !bus.m_axi_awready;
        stall_addr = bus.m_axi_awaddr;
        stall_len  = bus.m_axi_awlen;
        w_stall    = bus.m_axi_wvalid && !bus.m_axi_wready;
        if (bus.m_axi_awvalid) aw_valid_cycles++;
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          aw_addr_log.push_back(bus.m_axi_awaddr);
          aw_len_log.push_back(bus.m_axi_awlen);
          aw_hs_cnt++;
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          w_data_log.push_back(bus.m_axi_wdata);
          w_last_log.push_back(bus.m_axi_wlast);
          rd_ptr++;
          w_taken = 1;
          if (bus.m_axi_wlast) begin
            wlast_cnt++;
            b_pending++;
          end
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) b_taken = 1;
        if (bus.o_write_done) done_cnt++;
      end
      @(negedge clk);
      if (!reset_n) begin
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
        bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
        aw_wait = 0; w_wait = 0; b_wait = 0; b_pending = 0;
        b_taken = 0; w_taken = 0; aw_stall = 0; w_stall = 0; fifo_hold = 0;
        aw_hs_cnt = 0; wlast_cnt = 0;
      end else begin
        if (seen_id != xfer_id) begin
          seen_id = xfer_id;
          aw_addr_log.delete(); aw_len_log.delete(); w_data_log.delete(); w_last_log.delete();
          rd_ptr = 0; done_cnt = 0; aw_valid_cycles = 0; viol = 0; b_index = 0;
          aw_hs_cnt = 0; wlast_cnt = 0;
        end
        if (bus.m_axi_awvalid) begin
          if (aw_wait >= aw_delay) begin bus.m_axi_awready = 1'b1; aw_wait = 0; end
          else begin bus.m_axi_awready = 1'b0; aw_wait++; end
        end else begin
          bus.m_axi_awready = 1'b0; aw_wait = 0;
        end
        if (w_taken) begin w_wait = 0; w_taken = 0; end
        if (w_rand) bus.m_axi_wready = 1'($urandom_range(0, 1));
        else if (w_wait >= w_delay) bus.m_axi_wready = 1'b1;
        else begin bus.m_axi_wready = 1'b0; w_wait++; end
        // A real FWFT FIFO never empties under a presented word, so only stall between beats.
        if (!empty_rand) fifo_hold = 0;
        else if (!w_stall) fifo_hold = ($urandom_range(0, 2) == 0);
        if (b_taken) begin
          bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
          b_taken = 0; b_pending--; b_index++;
        end
        if (!bus.m_axi_bvalid && b_pending > 0) begin
          if (b_wait >= b_delay) begin
            bus.m_axi_bvalid = 1'b1;
            bus.m_axi_bresp  = (b_index == err_burst) ? 2'b10 : 2'b00;
            b_wait = 0;
          end else b_wait++;
        end
      end
      bus.i_fifo_empty = fifo_hold || (rd_ptr >= xfer_beats);
      bus.i_w_data     = xfer_base + 32'(rd_ptr);
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [31:0] len, input logic [31:0] base,
                         output int cyc, output bit timed_out, output bit busy1,
                         output bit awv1, output bit err1);
    xfer_base  = base;
    xfer_beats = int'(len / 4);
    xfer_id++;
    build_model(a, len);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dst_addr = a; bus.i_total_len = len;
    cyc = 0; timed_out = 1; busy1 = 0; awv1 = 0; err1 = 0;
    for (int k = 0; k < 3000 && timed_out; k++) begin
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        busy1 = bus.o_busy; awv1 = bus.m_axi_awvalid; err1 = bus.o_error;
      end
      if (bus.o_write_done) timed_out = 0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.o_busy, bus.o_write_done,
         bus.o_error, bus.o_fifo_rd_en} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 0000000", {bus.m_axi_awvalid,
               bus.m_axi_wvalid, bus.m_axi_bready, bus.o_busy, bus.o_write_done, bus.o_error,
               bus.o_fifo_rd_en});
    end
    vectors++;
    if (bus.m_axi_awsize !== 3'd2) begin
      miscompares++; $display("FAIL awsize: got %0d required 2", bus.m_axi_awsize);
    end
    vectors++;
    if (bus.m_axi_awburst !== 2'b01) begin
      miscompares++; $display("FAIL awburst: got %b required 01", bus.m_axi_awburst);
    end
    vectors++;
    if (bus.m_axi_wstrb !== 4'hF) begin
      miscompares++; $display("FAIL wstrb: got %h required f", bus.m_axi_wstrb);
    end
  endtask

  task automatic test_single(input string name);
    int cyc; bit to, b1, a1, e1;
    aw_delay = 2; w_delay = 1; b_delay = 2; err_burst = -1; w_rand = 0; empty_rand = 0;
    do_xfer(32'h8000_0000, 32'd16, 32'hA000_0000, cyc, to, b1, a1, e1);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL %s timeout: no done pulse", name); end
    vectors++;
    if ({b1, a1} !== 2'b11) begin
      miscompares++; $display("FAIL %s busy_awvalid_after_start: got %b required 11", name, {b1, a1});
    end
    vectors++;
    if (aw_addr_log.size() !== 1) begin
      miscompares++; $display("FAIL %s aw_count: got %0d required 1", name, aw_addr_log.size());
    end else if (aw_addr_log[0] !== 32'h8000_0000 || aw_len_log[0] !== 8'd3) begin
      miscompares++;
      $display("FAIL %s aw: got %h/%0d required 80000000/3", name, aw_addr_log[0], aw_len_log[0]);
    end
    vectors++;
    if (w_data_log.size() !== 4) begin
      miscompares++; $display("FAIL %s pops: got %0d required 4", name, w_data_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (w_data_log[i] !== 32'hA000_0000 + 32'(i) || w_last_log[i] !== (i == 3)) begin
          miscompares++;
          $display("FAIL %s beat%0d: got %h last=%0d required %h last=%0d", name, i,
                   w_data_log[i], w_last_log[i], 32'hA000_0000 + 32'(i), (i == 3));
        end
      end
    end
    vectors++;
    if (done_cnt !== 1 || bus.o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s done: got pulses=%0d busy=%b required 1/0", name, done_cnt, bus.o_busy);
    end
    vectors++;
    if (viol !== 0) begin miscompares++; $display("FAIL %s protocol: got %0d violations required 0", name, viol); end
  endtask

  task automatic test_burst_split();
    logic [31:0] addrs[4];
    logic [31:0] lens[4];
    int cyc; bit to, b1, a1, e1;
    addrs = '{32'h8000_0000, 32'h8000_0FF0, 32'h1234_5FF3, 32'h0000_0000};
    lens  = '{32'd96, 32'd32, 32'd35, 32'd4096};
    for (int t = 0; t < 4; t++) begin
      aw_delay = $urandom_range(0, 2); w_delay = $urandom_range(0, 1); b_delay = $urandom_range(0, 2);
      err_burst = -1; w_rand = 0; empty_rand = 0;
      do_xfer(addrs[t], lens[t], $urandom, cyc, to, b1, a1, e1);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL split%0d timeout: no done pulse", t); end
      vectors++;
      if (aw_addr_log.size() !== exp_addr.size()) begin
        miscompares++;
        $display("FAIL split%0d aw_count: got %0d required %0d", t, aw_addr_log.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          vectors++;
          if (aw_addr_log[i] !== exp_addr[i] || aw_len_log[i] !== exp_len[i]) begin
            miscompares++;
            $display("FAIL split%0d aw%0d: got %h/%0d required %h/%0d", t, i, aw_addr_log[i],
                     aw_len_log[i], exp_addr[i], exp_len[i]);
          end
        end
      end
      vectors++;
      if (w_data_log.size() !== exp_last.size()) begin
        miscompares++;
        $display("FAIL split%0d pops: got %0d required %0d", t, w_data_log.size(), exp_last.size());
      end else begin
        for (int i = 0; i < exp_last.size(); i++) begin
          vectors++;
          if (w_data_log[i] !== xfer_base + 32'(i) || w_last_log[i] !== exp_last[i]) begin
            miscompares++;
            $display("FAIL split%0d beat%0d: got %h last=%0d required %h last=%0d", t, i,
                     w_data_log[i], w_last_log[i], xfer_base + 32'(i), exp_last[i]);
          end
        end
      end
      vectors++;
      if (viol !== 0 || done_cnt !== 1) begin
        miscompares++;
        $display("FAIL split%0d protocol_done: got viol=%0d done=%0d required 0/1", t, viol, done_cnt);
      end
    end
  endtask

  task automatic test_fifo_stall();
    logic [31:0] a, len;
    int cyc; bit to, b1, a1, e1;
    for (int t = 0; t < 6; t++) begin
      aw_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      err_burst = -1; w_rand = 1; empty_rand = 1;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      len = $urandom_range(1, 200);
      do_xfer(a, len, $urandom, cyc, to, b1, a1, e1);
      vectors++;
      if (to !== 1'b0) begin miscompares++; $display("FAIL stall%0d timeout: no done pulse", t); end
      vectors++;
      if (aw_addr_log.size() !== exp_addr.size()) begin
        miscompares++;
        $display("FAIL stall%0d aw_count: got %0d required %0d", t, aw_addr_log.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          vectors++;
          if (aw_addr_log[i] !== exp_addr[i] || aw_len_log[i] !== exp_len[i]) begin
            miscompares++;
            $display("FAIL stall%0d aw%0d: got %h/%0d required %h/%0d", t, i, aw_addr_log[i],
                     aw_len_log[i], exp_addr[i], exp_len[i]);
          end
        end
      end
      vectors++;
      if (w_data_log.size() !== exp_last.size()) begin
        miscompares++;
        $display("FAIL stall%0d pops: got %0d required %0d", t, w_data_log.size(), exp_last.size());
      end else begin
        for (int i = 0; i < exp_last.size(); i++) begin
          vectors++;
          if (w_data_log[i] !== xfer_base + 32'(i) || w_last_log[i] !== exp_last[i]) begin
            miscompares++;
            $display("FAIL stall%0d beat%0d: got %h last=%0d required %h last=%0d", t, i,
                     w_data_log[i], w_last_log[i], xfer_base + 32'(i), exp_last[i]);
          end
        end
      end
      vectors++;
      if (viol !== 0) begin miscompares++; $display("FAIL stall%0d protocol: got %0d violations required 0", t, viol); end
    end
    w_rand = 0; empty_rand = 0;
  endtask

  task automatic test_error();
    int cyc; bit to, b1, a1, e1;
    aw_delay = 1; w_delay = 0; b_delay = 1; err_burst = 0; w_rand = 0; empty_rand = 0;
    do_xfer(32'h8000_0000, 32'd96, 32'h5000_0000, cyc, to, b1, a1, e1);
    vectors++;
    if (to !== 1'b0 || done_cnt !== 1) begin
      miscompares++; $display("FAIL err_done: got timeout=%0d pulses=%0d required 0/1", to, done_cnt);
    end
    vectors++;
    if (aw_addr_log.size() !== 2) begin
      miscompares++; $display("FAIL err_second_burst: got %0d bursts required 2", aw_addr_log.size());
    end
    vectors++;
    if (bus.o_error !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky: got %b required 1", bus.o_error);
    end
    err_burst = -1;
    do_xfer(32'h8000_0100, 32'd16, 32'h6000_0000, cyc, to, b1, a1, e1);
    vectors++;
    if (e1 !== 1'b0 || bus.o_error !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got after_start=%b at_end=%b required 0/0", e1, bus.o_error);
    end
  endtask

  task automatic test_zero_len();
    logic [31:0] lens[2];
    int cyc; bit to, b1, a1, e1;
    lens = '{32'd0, 32'd3};
    for (int t = 0; t < 2; t++) begin
      do_xfer(32'h8000_0000, lens[t], 32'h0, cyc, to, b1, a1, e1);
      vectors++;
      if (to !== 1'b0 || cyc !== 2) begin
        miscompares++;
        $display("FAIL zero%0d done_latency: got %0d (timeout=%0d) required 2", t, cyc, to);
      end
      vectors++;
      if (aw_valid_cycles !== 0 || w_data_log.size() !== 0 || done_cnt !== 1) begin
        miscompares++;
        $display("FAIL zero%0d activity: got awvalid_cycles=%0d pops=%0d done=%0d required 0/0/1",
                 t, aw_valid_cycles, w_data_log.size(), done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    aw_delay = 0; w_delay = 3; b_delay = 0; err_burst = -1;
    xfer_base = 32'hC000_0000; xfer_beats = 16; xfer_id++;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_dst_addr = 32'h9000_0000; bus.i_total_len = 32'd64;
    @(negedge clk);
    bus.i_start = 1'b0;
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.m_axi_wvalid) seen = 1;
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rstmid_reach_w: got no wvalid within 200 cycles required wvalid"); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.o_busy, bus.o_write_done,
         bus.o_fifo_rd_en} !== 6'b0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %b required 000000", {bus.m_axi_awvalid, bus.m_axi_wvalid,
               bus.m_axi_bready, bus.o_busy, bus.o_write_done, bus.o_fifo_rd_en});
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_single("after_reset");
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    aw_delay = 0; w_delay = 0; b_delay = 0; err_burst = -1; w_rand = 0; empty_rand = 0;
    xfer_base = '0; xfer_beats = 0; xfer_id = 0;
    bus.i_start = 1'b0; bus.i_dst_addr = '0; bus.i_total_len = '0;
    do_reset();
    test_reset();
    test_single("single");
    test_burst_split();
    test_fifo_stall();
    test_error();
    test_zero_len();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
